// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the 8N1 serial transmitter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int DATA_BITS = 8;
    localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd139;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 24-bit down-counter giving a one-cycle tick every CLOCKS_PER_BAUD enabled cycles
module uart_baud_tick #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd139
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_tick
);
    localparam logic [23:0] RELOAD = CLOCKS_PER_BAUD - 24'd1;
    logic [23:0] r_cnt;
    assign o_tick = i_enable && (r_cnt == 24'd0);
    // Restart or a bit boundary reloads a full period; otherwise count down while enabled
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) r_cnt <= 24'd0;
        else if (i_restart || o_tick) r_cnt <= RELOAD;
        else if (i_enable) r_cnt <= r_cnt - 24'd1;
endmodule

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: byte-wide 8N1 serial transmitter, LSB first, registered line and busy outputs
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_uart_tx
);
    uart_state_t r_state, w_state;
    logic [2:0] r_idx, w_idx;
    logic [7:0] r_shift, w_shift;
    logic r_tx, w_tx, r_busy, w_busy;
    logic w_accept, w_tick;

    assign w_accept = i_wr && !r_busy;
    assign o_busy = r_busy;
    assign o_uart_tx = r_tx;

    uart_baud_tick #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_tick (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_restart(w_accept),
        .i_enable(r_state != IDLE),
        .o_tick(w_tick)
    );

    // Next frame state: the shift register drains toward bit 0 so the line always takes r_shift[0]
    always_comb begin
        w_state = r_state;
        w_idx = r_idx;
        w_shift = r_shift;
        w_tx = r_tx;
        w_busy = r_busy;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state = START;
                w_shift = i_data;
                w_tx = 1'b0;
                w_busy = 1'b1;
            end
            START: if (w_tick) begin
                w_state = DATA;
                w_idx = 3'd0;
                w_tx = r_shift[0];
                w_shift = {1'b1, r_shift[7:1]};
            end
            DATA: if (w_tick) begin
                if (r_idx == 3'(DATA_BITS - 1)) begin
                    w_state = STOP;
                    w_tx = 1'b1;
                end else begin
                    w_idx = r_idx + 3'd1;
                    w_tx = r_shift[0];
                    w_shift = {1'b1, r_shift[7:1]};
                end
            end
            STOP: if (w_tick) begin
                w_state = IDLE;
                w_busy = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any frame and returns the line high at once
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_idx <= 3'd0;
            r_shift <= 8'hFF;
            r_tx <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx <= w_idx;
            r_shift <= w_shift;
            r_tx <= w_tx;
            r_busy <= w_busy;
        end
endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: scoreboard bench for the 8N1 transmitter at N=139 (dut_a) and N=4 (dut_b)
module tb_uart_tx_8n1;
    localparam int NA = 139;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, wr_a, busy_a, tx_a;
    logic rst_n_b, wr_b, busy_b, tx_b;
    logic [7:0] data_a, data_b;

    uart_tx_8n1 #(.CLOCKS_PER_BAUD(24'd139)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n_a), .i_wr(wr_a), .i_data(data_a),
        .o_busy(busy_a), .o_uart_tx(tx_a)
    );
    uart_tx_8n1 #(.CLOCKS_PER_BAUD(24'd4)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n_b), .i_wr(wr_b), .i_data(data_b),
        .o_busy(busy_b), .o_uart_tx(tx_b)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int starts_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic tx_of(input int d);
        return d == 0 ? tx_a : tx_b;
    endfunction
    function automatic logic busy_of(input int d);
        return d == 0 ? busy_a : busy_b;
    endfunction
    function automatic logic rst_of(input int d);
        return d == 0 ? rst_n_a : rst_n_b;
    endfunction

    // Decode one frame starting at the negedge where the start bit was first seen
    task automatic decode(input int d);
        int n = d == 0 ? NA : NB;
        string p = d == 0 ? "a" : "b";
        logic [9:0] f;
        logic [7:0] e;
        logic mid;
        int hits;
        int bhits = 0;
        if (d == 1) starts_b.push_back(cyc);
        if ((d == 0 ? q_a.size() : q_b.size()) == 0) begin
            check({p, "_unexpected_frame"}, 1, 0);
            return;
        end
        e = d == 0 ? q_a.pop_front() : q_b.pop_front();
        f = {1'b1, e, 1'b0};
        for (int b = 0; b < 10; b++) begin
            hits = 0;
            mid = 1'bx;
            for (int c = 0; c < n; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (!rst_of(d)) return;
                if (tx_of(d) == f[b]) hits++;
                if (busy_of(d)) bhits++;
                if (c == n / 2) mid = tx_of(d);
            end
            check($sformatf("%s_%02h_bit%0d_val", p, e, b), {31'd0, mid}, {31'd0, f[b]});
            check($sformatf("%s_%02h_bit%0d_len", p, e, b), hits, n);
        end
        check($sformatf("%s_%02h_busy_frame", p, e), bhits, 10 * n);
        @(negedge clk);
        if (!rst_of(d)) return;
        check($sformatf("%s_%02h_end_busy", p, e), {31'd0, busy_of(d)}, 0);
        check($sformatf("%s_%02h_end_tx", p, e), {31'd0, tx_of(d)}, 1);
    endtask

    task automatic monitor(input int d);
        logic prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_of(d)) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !tx_of(d)) decode(d);
            prev = tx_of(d);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic send_a(input logic [7:0] v);
        q_a.push_back(v);
        @(negedge clk);
        wr_a = 1'b1;
        data_a = v;
        @(negedge clk);
        wr_a = 1'b0;
        data_a = 8'($urandom);
        check("a_busy_rise", {31'd0, busy_a}, 1);
    endtask

    task automatic send_b(input logic [7:0] v);
        q_b.push_back(v);
        @(negedge clk);
        wr_b = 1'b1;
        data_b = v;
        @(negedge clk);
        wr_b = 1'b0;
        data_b = 8'($urandom);
        check("b_busy_rise", {31'd0, busy_b}, 1);
    endtask

    initial begin
        int bad = 0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        wr_a = 1'b0;
        wr_b = 1'b0;
        data_a = 8'h00;
        data_b = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_tx_a", {31'd0, tx_a}, 1);
        check("rst_busy_a", {31'd0, busy_a}, 0);
        check("rst_tx_b", {31'd0, tx_b}, 1);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("idle_200", bad, 0);

        send_a(8'h55);
        repeat (10 * NA + 10) @(negedge clk);

        send_b(8'hA3);
        repeat (50) @(negedge clk);

        starts_b.delete();
        send_b(8'h0F);
        repeat (9) @(negedge clk);
        wr_b = 1'b1;
        data_b = 8'hFF;
        @(negedge clk);
        wr_b = 1'b0;
        check("b_busy_ignored_wr", {31'd0, busy_b}, 1);
        repeat (60) @(negedge clk);
        check("b_single_frame", starts_b.size(), 1);

        starts_b.delete();
        q_b.push_back(8'h41);
        q_b.push_back(8'h42);
        @(negedge clk);
        wr_b = 1'b1;
        data_b = 8'h41;
        @(negedge clk);
        data_b = 8'h42;
        repeat (10 * NB + 1) @(negedge clk);
        wr_b = 1'b0;
        check("b_b2b_busy", {31'd0, busy_b}, 1);
        repeat (60) @(negedge clk);
        check("b_b2b_frames", starts_b.size(), 2);
        if (starts_b.size() == 2) check("b_b2b_gap", starts_b[1] - starts_b[0], 10 * NB + 1);

        send_a(8'hC6);
        repeat (499) @(negedge clk);
        #2 rst_n_a = 1'b0;
        #1;
        check("a_async_rst_tx", {31'd0, tx_a}, 1);
        check("a_async_rst_busy", {31'd0, busy_a}, 0);
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1;
        @(negedge clk);
        send_a(8'h00);
        repeat (10 * NA + 10) @(negedge clk);

        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
